// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
//
// Runs the single-obstacle collision engine once for every obstacle in the
// scene during one physics step. For each obstacle it addresses the vertex
// ROM, launches the engine, waits for its done pulse, and folds the engine's
// corrected endpoint, velocity and acceleration into the working state that
// the next obstacle check starts from. Acceleration contributions are summed
// with saturation.
//
// Optional feature (macro OBSTACLE_SCHEDULER_TIMEOUT_EN):
//   A watchdog skips an obstacle whose engine run does not answer within
//   TIMEOUT_CYCLES wait cycles and raises the sticky timeout_out flag.
//   Without the macro the scheduler waits on the engine indefinitely and the
//   timeout_out port does not exist.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   begin_in                start-of-step pulse (ignored while busy_out)
//   num_obstacles_in        obstacles to process (clamped to NUM_OBSTACLES)
//   pos/vel/dx/dy *_in      start position, velocity and step displacement
//   obs_idx_out             obstacle vertex ROM address (1-cycle ROM latency)
//   coll_begin_out          one-cycle launch pulse to the collision engine
//   coll_* _out             engine operands, stable from launch through wait
//   coll_result_in          engine done pulse
//   coll_was_collision_in   engine saw at least one edge hit
//   coll_*_new_in, coll_acc engine post-collision state and acceleration
//   busy_out, done_out      step in progress / one-cycle completion pulse
//   x/y/vel/acc_out         final state, held until the next done_out
//   hit_count_out           number of obstacles that reported a collision
//   timeout_out             sticky watchdog flag (optional feature only)
// -----------------------------------------------------------------------------
module obstacle_scheduler #(
  parameter int POSITION_SIZE     = 8,
  parameter int VELOCITY_SIZE     = 8,
  parameter int ACCELERATION_SIZE = 8,
  parameter int NUM_OBSTACLES     = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                begin_in,
  input  logic [$clog2(NUM_OBSTACLES):0]      num_obstacles_in,
  input  logic signed [POSITION_SIZE-1:0]     pos_x_in,
  input  logic signed [POSITION_SIZE-1:0]     pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0]     vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0]     vel_y_in,
  input  logic signed [POSITION_SIZE-1:0]     dx_in,
  input  logic signed [POSITION_SIZE-1:0]     dy_in,
  output logic [$clog2(NUM_OBSTACLES)-1:0]    obs_idx_out,
  output logic                                coll_begin_out,
  output logic signed [POSITION_SIZE-1:0]     coll_pos_x_out,
  output logic signed [POSITION_SIZE-1:0]     coll_pos_y_out,
  output logic signed [VELOCITY_SIZE-1:0]     coll_vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0]     coll_vel_y_out,
  output logic signed [POSITION_SIZE-1:0]     coll_dx_out,
  output logic signed [POSITION_SIZE-1:0]     coll_dy_out,
  input  logic                                coll_result_in,
  input  logic                                coll_was_collision_in,
  input  logic signed [POSITION_SIZE-1:0]     coll_x_new_in,
  input  logic signed [POSITION_SIZE-1:0]     coll_y_new_in,
  input  logic signed [VELOCITY_SIZE-1:0]     coll_vx_new_in,
  input  logic signed [VELOCITY_SIZE-1:0]     coll_vy_new_in,
  input  logic signed [ACCELERATION_SIZE-1:0] coll_acc_x_in,
  input  logic signed [ACCELERATION_SIZE-1:0] coll_acc_y_in,
  output logic                                busy_out,
  output logic                                done_out,
  output logic signed [POSITION_SIZE-1:0]     x_out,
  output logic signed [POSITION_SIZE-1:0]     y_out,
  output logic signed [VELOCITY_SIZE-1:0]     vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0]     vel_y_out,
  output logic signed [ACCELERATION_SIZE-1:0] acc_x_out,
  output logic signed [ACCELERATION_SIZE-1:0] acc_y_out,
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
  output logic                                timeout_out,
`endif
  output logic [$clog2(NUM_OBSTACLES):0]      hit_count_out
);

  localparam int IDX_W = $clog2(NUM_OBSTACLES);
  localparam int CNT_W = IDX_W + 1;
  localparam int PW    = POSITION_SIZE;
  localparam int VW    = VELOCITY_SIZE;
  localparam int AW    = ACCELERATION_SIZE;

  // Elaboration-time sanity checks on the configuration.
  if (NUM_OBSTACLES < 2) begin : g_bad_num_obstacles
    $error("obstacle_scheduler: NUM_OBSTACLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("obstacle_scheduler: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_e;

  // Saturating signed add at the acceleration width.
  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    logic signed [AW:0] sum;
    sum = {a[AW-1], a} + {b[AW-1], b};
    // Sign bit and the bit below it disagree only on overflow.
    if (sum[AW] != sum[AW-1]) begin
      sat_add = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      sat_add = sum[AW-1:0];
    end
  endfunction

  // Control state
  state_e                 state_q;
  logic [CNT_W-1:0]       n_q;
  logic [IDX_W-1:0]       idx_q;

  // Working registers carried from one obstacle check to the next
  logic signed [PW-1:0]   start_x_q, start_y_q;
  logic signed [PW-1:0]   cur_x_q, cur_y_q;
  logic signed [VW-1:0]   cur_vx_q, cur_vy_q;
  logic signed [PW-1:0]   cur_dx_q, cur_dy_q;
  logic signed [AW-1:0]   acc_x_q, acc_y_q;
  logic [CNT_W-1:0]       hit_q;

  // Registered outputs
  logic                   busy_q, done_q, coll_begin_q;
  logic signed [PW-1:0]   coll_pos_x_q, coll_pos_y_q, coll_dx_q, coll_dy_q;
  logic signed [VW-1:0]   coll_vel_x_q, coll_vel_y_q;
  logic signed [PW-1:0]   x_q, y_q;
  logic signed [VW-1:0]   vel_x_q, vel_y_q;
  logic signed [AW-1:0]   acc_x_out_q, acc_y_out_q;
  logic [CNT_W-1:0]       hit_count_q;

`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WAIT_W-1:0]      wait_cnt_q;
  logic                   timeout_q;
`endif

  // Next-state values computed outside the FSM block
  logic [CNT_W-1:0]       n_d;
  logic signed [AW-1:0]   acc_x_d, acc_y_d;
  logic                   last_obs;

  // NOTE: every signal written in an always_comb block gets a value on every
  // path (here a default at the top), otherwise a latch is inferred.
  always_comb begin
    n_d     = num_obstacles_in;
    acc_x_d = sat_add(acc_x_q, coll_acc_x_in);
    acc_y_d = sat_add(acc_y_q, coll_acc_y_in);
    if (num_obstacles_in > CNT_W'(NUM_OBSTACLES)) begin
      n_d = CNT_W'(NUM_OBSTACLES);
    end
  end

  assign last_obs = ({1'b0, idx_q} == (n_q - CNT_W'(1)));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the values from before the clock edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      start_x_q    <= '0;
      start_y_q    <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_vx_q     <= '0;
      cur_vy_q     <= '0;
      cur_dx_q     <= '0;
      cur_dy_q     <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      hit_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      coll_begin_q <= 1'b0;
      coll_pos_x_q <= '0;
      coll_pos_y_q <= '0;
      coll_vel_x_q <= '0;
      coll_vel_y_q <= '0;
      coll_dx_q    <= '0;
      coll_dy_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      acc_x_out_q  <= '0;
      acc_y_out_q  <= '0;
      hit_count_q  <= '0;
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      // Pulses default low and are raised only in their single state.
      done_q       <= 1'b0;
      coll_begin_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (begin_in) begin
            start_x_q <= pos_x_in;
            start_y_q <= pos_y_in;
            cur_x_q   <= pos_x_in;
            cur_y_q   <= pos_y_in;
            cur_vx_q  <= vel_x_in;
            cur_vy_q  <= vel_y_in;
            cur_dx_q  <= dx_in;
            cur_dy_q  <= dy_in;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            hit_q     <= '0;
            idx_q     <= '0;
            n_q       <= n_d;
            busy_q    <= 1'b1;
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            state_q   <= (n_d == '0) ? S_DONE : S_FETCH;
          end
        end

        // ROM address (idx_q) is already valid; this cycle lets the vertex
        // read settle before the engine is launched.
        S_FETCH: begin
          coll_begin_q <= 1'b1;
          coll_pos_x_q <= cur_x_q;
          coll_pos_y_q <= cur_y_q;
          coll_vel_x_q <= cur_vx_q;
          coll_vel_y_q <= cur_vy_q;
          coll_dx_q    <= cur_dx_q;
          coll_dy_q    <= cur_dy_q;
          state_q      <= S_LAUNCH;
        end

        S_LAUNCH: begin
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end

        // The engine's result is folded in on the edge that sees its done
        // pulse, so the engine need not hold its outputs past that pulse.
        // UPDATE then only decides where to go next.
        S_WAIT: begin
          if (coll_result_in) begin
            if (coll_was_collision_in) begin
              cur_x_q  <= coll_x_new_in;
              cur_y_q  <= coll_y_new_in;
              cur_vx_q <= coll_vx_new_in;
              cur_vy_q <= coll_vy_new_in;
              // Keep the original start so the next obstacle checks the
              // segment from start to the corrected endpoint.
              cur_dx_q <= coll_x_new_in - start_x_q;
              cur_dy_q <= coll_y_new_in - start_y_q;
              acc_x_q  <= acc_x_d;
              acc_y_q  <= acc_y_d;
              hit_q    <= hit_q + CNT_W'(1);
            end
            state_q <= S_UPDATE;
          end
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            // Skip this obstacle as if it reported no collision.
            timeout_q <= 1'b1;
            state_q   <= S_UPDATE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
`endif
        end

        S_UPDATE: begin
          if (last_obs) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_FETCH;
          end
        end

        S_DONE: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          x_q         <= start_x_q + cur_dx_q;
          y_q         <= start_y_q + cur_dy_q;
          vel_x_q     <= cur_vx_q;
          vel_y_q     <= cur_vy_q;
          acc_x_out_q <= acc_x_q;
          acc_y_out_q <= acc_y_q;
          hit_count_q <= hit_q;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign obs_idx_out    = idx_q;
  assign coll_begin_out = coll_begin_q;
  assign coll_pos_x_out = coll_pos_x_q;
  assign coll_pos_y_out = coll_pos_y_q;
  assign coll_vel_x_out = coll_vel_x_q;
  assign coll_vel_y_out = coll_vel_y_q;
  assign coll_dx_out    = coll_dx_q;
  assign coll_dy_out    = coll_dy_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign x_out          = x_q;
  assign y_out          = y_q;
  assign vel_x_out      = vel_x_q;
  assign vel_y_out      = vel_y_q;
  assign acc_x_out      = acc_x_out_q;
  assign acc_y_out      = acc_y_out_q;
  assign hit_count_out  = hit_count_q;
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
  assign timeout_out    = timeout_q;
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// tb_obstacle_scheduler
//
// Directed bench for obstacle_scheduler. A small behavioural engine model
// answers each launch after a programmable number of wait cycles with a
// per-obstacle canned response, and records the operands of every launch.
// Step latency is counted from the cycle begin_in is driven to the cycle
// done_out is first seen: accept plus DONE (2), and per obstacle FETCH,
// LAUNCH, UPDATE plus the engine's wait cycles.
// -----------------------------------------------------------------------------
module tb_obstacle_scheduler;

  localparam int PW = 8;
  localparam int VW = 8;
  localparam int AW = 8;
  localparam int NO = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_in;
  logic                 begin_in;
  logic [2:0]           num_obstacles_in;
  logic signed [PW-1:0] pos_x_in, pos_y_in, dx_in, dy_in;
  logic signed [VW-1:0] vel_x_in, vel_y_in;
  logic [1:0]           obs_idx_out;
  logic                 coll_begin_out;
  logic signed [PW-1:0] coll_pos_x_out, coll_pos_y_out, coll_dx_out, coll_dy_out;
  logic signed [VW-1:0] coll_vel_x_out, coll_vel_y_out;
  logic                 coll_result_in;
  logic                 coll_was_collision_in;
  logic signed [PW-1:0] coll_x_new_in, coll_y_new_in;
  logic signed [VW-1:0] coll_vx_new_in, coll_vy_new_in;
  logic signed [AW-1:0] coll_acc_x_in, coll_acc_y_in;
  logic                 busy_out, done_out;
  logic signed [PW-1:0] x_out, y_out;
  logic signed [VW-1:0] vel_x_out, vel_y_out;
  logic signed [AW-1:0] acc_x_out, acc_y_out;
  logic [2:0]           hit_count_out;
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
  logic                 timeout_out;
`endif

  obstacle_scheduler #(
    .POSITION_SIZE(PW), .VELOCITY_SIZE(VW), .ACCELERATION_SIZE(AW),
    .NUM_OBSTACLES(NO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .begin_in(begin_in),
    .num_obstacles_in(num_obstacles_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
    .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .dx_in(dx_in), .dy_in(dy_in),
    .obs_idx_out(obs_idx_out), .coll_begin_out(coll_begin_out),
    .coll_pos_x_out(coll_pos_x_out), .coll_pos_y_out(coll_pos_y_out),
    .coll_vel_x_out(coll_vel_x_out), .coll_vel_y_out(coll_vel_y_out),
    .coll_dx_out(coll_dx_out), .coll_dy_out(coll_dy_out),
    .coll_result_in(coll_result_in), .coll_was_collision_in(coll_was_collision_in),
    .coll_x_new_in(coll_x_new_in), .coll_y_new_in(coll_y_new_in),
    .coll_vx_new_in(coll_vx_new_in), .coll_vy_new_in(coll_vy_new_in),
    .coll_acc_x_in(coll_acc_x_in), .coll_acc_y_in(coll_acc_y_in),
    .busy_out(busy_out), .done_out(done_out),
    .x_out(x_out), .y_out(y_out),
    .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
    .acc_x_out(acc_x_out), .acc_y_out(acc_y_out),
`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
    .timeout_out(timeout_out),
`endif
    .hit_count_out(hit_count_out)
  );

  int total = 0;
  int bad   = 0;

  // Engine model configuration (written by the stimulus only)
  int eng_lat = 1;
  int eng_hit[NO], eng_x[NO], eng_y[NO], eng_vx[NO], eng_vy[NO], eng_ax[NO], eng_ay[NO];
  bit eng_silent[NO];

  // Engine model state and launch log (written by the model only)
  int eng_cnt = 0;
  int eng_sel = 0;
  int launch_cnt = 0;
  int done_cnt = 0;
  int l_idx[64], l_px[64], l_py[64], l_vx[64], l_vy[64], l_dx[64], l_dy[64];

  always @(negedge clk) begin
    coll_result_in <= 1'b0;
    if (done_out) done_cnt <= done_cnt + 1;
    if (eng_cnt == 1) begin
      coll_result_in        <= 1'b1;
      coll_was_collision_in <= (eng_hit[eng_sel] != 0);
      coll_x_new_in         <= PW'(eng_x[eng_sel]);
      coll_y_new_in         <= PW'(eng_y[eng_sel]);
      coll_vx_new_in        <= VW'(eng_vx[eng_sel]);
      coll_vy_new_in        <= VW'(eng_vy[eng_sel]);
      coll_acc_x_in         <= AW'(eng_ax[eng_sel]);
      coll_acc_y_in         <= AW'(eng_ay[eng_sel]);
      eng_cnt               <= 0;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
    if (coll_begin_out) begin
      l_idx[launch_cnt & 63] <= int'(obs_idx_out);
      l_px[launch_cnt & 63]  <= int'(coll_pos_x_out);
      l_py[launch_cnt & 63]  <= int'(coll_pos_y_out);
      l_vx[launch_cnt & 63]  <= int'(coll_vel_x_out);
      l_vy[launch_cnt & 63]  <= int'(coll_vel_y_out);
      l_dx[launch_cnt & 63]  <= int'(coll_dx_out);
      l_dy[launch_cnt & 63]  <= int'(coll_dy_out);
      launch_cnt             <= launch_cnt + 1;
      if (!eng_silent[obs_idx_out]) begin
        eng_cnt <= eng_lat;
        eng_sel <= int'(obs_idx_out);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_engine();
    for (int i = 0; i < NO; i++) begin
      eng_hit[i] = 0; eng_x[i] = 0; eng_y[i] = 0; eng_vx[i] = 0;
      eng_vy[i] = 0; eng_ax[i] = 0; eng_ay[i] = 0; eng_silent[i] = 1'b0;
    end
  endtask

  task automatic set_resp(input int i, input int hit, input int x, input int y,
                          input int vx, input int vy, input int ax, input int ay);
    eng_hit[i] = hit; eng_x[i] = x; eng_y[i] = y; eng_vx[i] = vx;
    eng_vy[i] = vy; eng_ax[i] = ax; eng_ay[i] = ay;
  endtask

  // Called on a falling edge; drives begin_in immediately and returns on the
  // falling edge where done_out is first seen (or when the budget expires).
  task automatic run_step(input int n, input int px, input int py, input int vx,
                          input int vy, input int dx, input int dy,
                          output int cycles, output int base);
    base             = launch_cnt;
    num_obstacles_in = 3'(n);
    pos_x_in = PW'(px); pos_y_in = PW'(py);
    vel_x_in = VW'(vx); vel_y_in = VW'(vy);
    dx_in    = PW'(dx); dy_in    = PW'(dy);
    begin_in = 1'b1;
    @(negedge clk);
    begin_in = 1'b0;
    cycles   = 1;
    while (!done_out && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", int'(done_out), 1);
  endtask

  task automatic check_final(input int x, input int y, input int vx, input int vy,
                             input int ax, input int ay, input int hits);
    check("x_out", int'(x_out), x);
    check("y_out", int'(y_out), y);
    check("vel_x_out", int'(vel_x_out), vx);
    check("vel_y_out", int'(vel_y_out), vy);
    check("acc_x_out", int'(acc_x_out), ax);
    check("acc_y_out", int'(acc_y_out), ay);
    check("hit_count", int'(hit_count_out), hits);
    check("busy_at_done", int'(busy_out), 0);
  endtask

  int cyc, base, saved_done, saved_launch;

  initial begin
    rst_in = 1'b1; begin_in = 1'b0; num_obstacles_in = '0;
    pos_x_in = '0; pos_y_in = '0; vel_x_in = '0; vel_y_in = '0; dx_in = '0; dy_in = '0;
    clear_engine();
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_coll_begin", int'(coll_begin_out), 0);
    rst_in = 1'b0;
    @(negedge clk);
    check("idle_obs_idx", int'(obs_idx_out), 0);
    check("idle_x_out", int'(x_out), 0);

    // n = 0: straight to DONE, position = pos + d
    run_step(0, 10, 20, 1, 1, 3, -2, cyc, base);
    check("n0_latency", cyc, 2);
    check("n0_launches", launch_cnt - base, 0);
    check_final(13, 18, 1, 1, 0, 0, 0);

    // n = 3, never collides, 5 wait cycles each; issued the cycle after done
    eng_lat = 5;
    run_step(3, 7, -4, 2, -3, 10, 6, cyc, base);
    check("n3_latency", cyc, 2 + 3 * (3 + 5));
    check("n3_launches", launch_cnt - base, 3);
    for (int k = 0; k < 3; k++) begin
      check("n3_launch_idx", l_idx[(base + k) & 63], k);
      check("n3_launch_dx", l_dx[(base + k) & 63], 10);
    end
    check_final(17, 2, 2, -3, 0, 0, 0);

    // n = 2, obstacle 0 collides; obstacle 1 data must be ignored
    eng_lat = 2;
    set_resp(0, 1, 5, 5, -1, 2, 3, 4);
    set_resp(1, 0, 99, 99, 9, 9, 50, 50);
    run_step(2, 0, 0, 1, 1, 8, 8, cyc, base);
    check("hit_latency", cyc, 2 + 2 * (3 + 2));
    check("hit_l0_dx", l_dx[base & 63], 8);
    check("hit_l0_vx", l_vx[base & 63], 1);
    check("hit_l1_px", l_px[(base + 1) & 63], 5);
    check("hit_l1_dx", l_dx[(base + 1) & 63], 5);
    check("hit_l1_dy", l_dy[(base + 1) & 63], 5);
    check("hit_l1_vx", l_vx[(base + 1) & 63], -1);
    check("hit_l1_vy", l_vy[(base + 1) & 63], 2);
    check_final(5, 5, -1, 2, 3, 4, 1);

    // Saturation: 100 + 100 -> 127 and -100 + -100 -> -128; start (10,10)
    set_resp(0, 1, 1, 2, 0, 0, 100, -100);
    set_resp(1, 1, 3, 4, 5, 6, 100, -100);
    run_step(2, 10, 10, 0, 0, 0, 0, cyc, base);
    check("sat_l1_dx", l_dx[(base + 1) & 63], -9);
    check("sat_l1_dy", l_dy[(base + 1) & 63], -8);
    check_final(3, 4, 5, 6, 127, -128, 2);

    // num_obstacles_in = 7 clamps to 4; position wraps at 8 bits
    clear_engine();
    eng_lat = 1;
    run_step(7, 120, -120, 3, 4, 20, -20, cyc, base);
    check("clamp_latency", cyc, 2 + 4 * (3 + 1));
    check("clamp_launches", launch_cnt - base, 4);
    check("clamp_last_idx", l_idx[(base + 3) & 63], 3);
    check_final(-116, 116, 3, 4, 0, 0, 0);

`ifdef OBSTACLE_SCHEDULER_TIMEOUT_EN
    // Obstacle 0 never answers: skipped after TO wait cycles, obstacle 1 runs
    eng_lat = 2;
    eng_silent[0] = 1'b1;
    run_step(2, 1, 2, 0, 0, 4, 4, cyc, base);
    check("to_latency", cyc, 2 + (3 + TO) + (3 + 2));
    check("to_flag", int'(timeout_out), 1);
    check("to_launches", launch_cnt - base, 2);
    check("to_l1_idx", l_idx[(base + 1) & 63], 1);
    check_final(5, 6, 0, 0, 0, 0, 0);
    eng_silent[0] = 1'b0;
    run_step(0, 0, 0, 0, 0, 0, 0, cyc, base);
    check("to_flag_cleared", int'(timeout_out), 0);
`endif

    // Second begin while busy is ignored; reset mid-WAIT aborts the step
    clear_engine();
    eng_silent[0] = 1'b1;
    base = launch_cnt;
    num_obstacles_in = 3'd2;
    pos_x_in = 8'sd40; pos_y_in = 8'sd41; vel_x_in = 8'sd1; vel_y_in = 8'sd1;
    dx_in = 8'sd1; dy_in = 8'sd1;
    begin_in = 1'b1;
    @(negedge clk);
    begin_in = 1'b0;
    repeat (6) @(negedge clk);
    num_obstacles_in = 3'd1; pos_x_in = 8'sd77;
    begin_in = 1'b1;
    @(negedge clk);
    begin_in = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_mid_wait", int'(busy_out), 1);
    check("busy_launches", launch_cnt - base, 1);
    check("busy_coll_pos_x", int'(coll_pos_x_out), 40);
    saved_done   = done_cnt;
    saved_launch = launch_cnt;
    rst_in = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy_out), 0);
    check("abort_x_out", int'(x_out), 0);
    check("abort_y_out", int'(y_out), 0);
    check("abort_vel_x", int'(vel_x_out), 0);
    check("abort_coll_pos_x", int'(coll_pos_x_out), 0);
    check("abort_coll_dx", int'(coll_dx_out), 0);
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    eng_silent[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt, saved_done);
    check("abort_no_launch", launch_cnt, saved_launch);

    // Scheduler is back in IDLE and accepts a fresh step
    run_step(0, -5, 6, 7, -8, 2, 2, cyc, base);
    check("post_rst_latency", cyc, 2);
    check_final(-3, 8, 7, -8, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
